writeback_unit: RTL and testbench



---
 rtl/writeback_unit.sv | 124 ++++++++++++
 tb/tb_writeback_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage of the core. It registers one instruction
// per cycle from the memory stage and selects the register-file write value
// from the ALU, load, PC+4 or CSR sources. It lane-selects and extends load data,
// suppresses writes to x0 and counts retired instructions.
module writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned INSTRET_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_result_src,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_read_data,
  input  logic [XLEN-1:0]       mem_instr_addr_plus,
  input  logic [XLEN-1:0]       mem_csr_data,
  input  logic [2:0]            mem_load_funct3,
  input  logic                  mem_wr_enable,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_write_data,
  output logic                  wb_wr_enable,
  output logic [INSTRET_W-1:0]  wb_instret
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_CSR  = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_D  = 3'b011,
    LD_BU = 3'b100,
    LD_HU = 3'b101,
    LD_WU = 3'b110
  } load_type_e;

  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [XLEN-1:0]  byte_lane;
  logic [XLEN-1:0]  half_lane;
  logic [XLEN-1:0]  word_lane;
  logic [XLEN-1:0]  load_value;
  logic [XLEN-1:0]  result_value;
  logic             wr_next;
  logic             capture;
  logic             retire;

  // Byte offset within the data word, aligned down to the access size.
  assign off   = mem_alu_result[OFF_W-1:0];
  assign off_h = off & ~OFF_W'(1);
  assign off_w = off & ~OFF_W'(3);

  // Shift the addressed lane down to bit 0; misaligned offsets are not trapped.
  assign byte_lane = mem_read_data >> {off, 3'b000};
  assign half_lane = mem_read_data >> {off_h, 3'b000};
  assign word_lane = mem_read_data >> {off_w, 3'b000};

  // Load extension; unknown codes and 64-bit-only codes on RV32 pass the raw word.
  always_comb begin
    load_value = mem_read_data;
    case (mem_load_funct3)
      LD_B:    load_value = XLEN'($signed(byte_lane[7:0]));
      LD_H:    load_value = XLEN'($signed(half_lane[15:0]));
      LD_W:    load_value = XLEN'($signed(word_lane[31:0]));
      LD_D:    load_value = mem_read_data;
      LD_BU:   load_value = XLEN'(byte_lane[7:0]);
      LD_HU:   load_value = XLEN'(half_lane[15:0]);
      LD_WU:   load_value = (XLEN == 64) ? XLEN'(word_lane[31:0]) : mem_read_data;
      default: load_value = mem_read_data;
    endcase
  end

  // Result source mux; every encoding selects a real source.
  always_comb begin
    result_value = mem_alu_result;
    case (result_src_e'(mem_result_src))
      SRC_ALU:  result_value = mem_alu_result;
      SRC_LOAD: result_value = load_value;
      SRC_PC4:  result_value = mem_instr_addr_plus;
      SRC_CSR:  result_value = mem_csr_data;
      default:  result_value = mem_alu_result;
    endcase
  end

  assign wr_next = mem_valid & mem_wr_enable & (mem_rd != '0);
  // Flush still loads rd/data so they stay deterministic; only valid/wr are killed.
  assign capture = flush | ~stall;
  assign retire  = ~flush & ~stall & mem_valid;

  // WB pipeline registers and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_write_data <= '0;
      wb_wr_enable  <= 1'b0;
      wb_instret    <= '0;
    end else begin
      if (capture) begin
        wb_valid      <= mem_valid & ~flush;
        wb_rd         <= mem_rd;
        wb_write_data <= result_value;
        wb_wr_enable  <= wr_next & ~flush;
      end
      if (retire) begin
        wb_instret <= wb_instret + INSTRET_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and random checks of writeback_unit in three
// configurations (RV32, RV64, RV32 with a 4-bit retire counter) against a
// behavioural model of the writeback rules.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [1:0]  src;
  logic [63:0] alu, rdata, pc4, csr;
  logic [2:0]  f3;
  logic        wr, stall, flush;

  logic        v32, v64, vw;
  logic [4:0]  rd32, rd64, rdw;
  logic [31:0] d32, dw;
  logic [63:0] d64;
  logic        we32, we64, wew;
  logic [63:0] i32, i64;
  logic [3:0]  iw;

  int compared   = 0;
  int mismatched = 0;

  // Model state per DUT: 0 = RV32, 1 = RV64, 2 = RV32 with 4-bit counter.
  int          xl_of [3] = '{32, 64, 32};
  int          iw_of [3] = '{64, 64, 4};
  logic        m_valid [3];
  logic [4:0]  m_rd    [3];
  logic [63:0] m_data  [3];
  logic        m_wr    [3];
  logic [63:0] m_inst  [3];

  always #5 clk = ~clk;

  writeback_unit dut32 (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_result_src(src), .mem_alu_result(alu[31:0]), .mem_read_data(rdata[31:0]),
    .mem_instr_addr_plus(pc4[31:0]), .mem_csr_data(csr[31:0]), .mem_load_funct3(f3),
    .mem_wr_enable(wr), .stall(stall), .flush(flush),
    .wb_valid(v32), .wb_rd(rd32), .wb_write_data(d32), .wb_wr_enable(we32), .wb_instret(i32)
  );

  writeback_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_result_src(src), .mem_alu_result(alu), .mem_read_data(rdata),
    .mem_instr_addr_plus(pc4), .mem_csr_data(csr), .mem_load_funct3(f3),
    .mem_wr_enable(wr), .stall(stall), .flush(flush),
    .wb_valid(v64), .wb_rd(rd64), .wb_write_data(d64), .wb_wr_enable(we64), .wb_instret(i64)
  );

  writeback_unit #(.INSTRET_W(4)) dutw (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_result_src(src), .mem_alu_result(alu[31:0]), .mem_read_data(rdata[31:0]),
    .mem_instr_addr_plus(pc4[31:0]), .mem_csr_data(csr[31:0]), .mem_load_funct3(f3),
    .mem_wr_enable(wr), .stall(stall), .flush(flush),
    .wb_valid(vw), .wb_rd(rdw), .wb_write_data(dw), .wb_wr_enable(wew), .wb_instret(iw)
  );

  function automatic logic [63:0] mask_x(int xl, logic [63:0] v);
    return (xl == 64) ? v : {32'h0, v[31:0]};
  endfunction

  // Load extension computed arithmetically from the offset and access size.
  function automatic logic [63:0] load_ext(int xl, logic [2:0] code, logic [63:0] addr,
                                           logic [63:0] data);
    int              nb  = xl / 8;
    int              off = int'(addr % 64'(nb));
    longint unsigned d   = mask_x(xl, data);
    longint unsigned b   = (d >> (8 * off)) & 64'hFF;
    longint unsigned h   = (d >> (8 * (off - off % 2))) & 64'hFFFF;
    longint unsigned w   = (d >> (8 * (off - off % 4))) & 64'hFFFF_FFFF;
    longint          s;
    case (code)
      3'd0: s = (b >= 128)        ? longint'(b) - 256        : longint'(b);
      3'd1: s = (h >= 32768)      ? longint'(h) - 65536      : longint'(h);
      3'd2: s = (w >= 64'h8000_0000) ? longint'(w) - 64'sh1_0000_0000 : longint'(w);
      3'd4: return b;
      3'd5: return h;
      3'd6: return (xl == 64) ? w : d;
      default: return d;
    endcase
    return mask_x(xl, 64'(s));
  endfunction

  function automatic logic [63:0] expect_data(int xl);
    case (src)
      2'b00:   return mask_x(xl, alu);
      2'b01:   return load_ext(xl, f3, alu, rdata);
      2'b10:   return mask_x(xl, pc4);
      default: return mask_x(xl, csr);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0; m_rd[k] = '0; m_data[k] = '0; m_wr[k] = 1'b0; m_inst[k] = '0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (!stall && !flush && mem_valid)
        m_inst[k] = (iw_of[k] == 64) ? m_inst[k] + 64'd1
                                     : (m_inst[k] + 64'd1) % (64'd1 << iw_of[k]);
      if (flush || !stall) begin
        m_valid[k] = mem_valid && !flush;
        m_rd[k]    = mem_rd;
        m_data[k]  = expect_data(xl_of[k]);
        m_wr[k]    = mem_valid && wr && (mem_rd != 5'd0) && !flush;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".32.valid"}, 64'(v32),  64'(m_valid[0]));
    chk({tag, ".32.rd"},    64'(rd32), 64'(m_rd[0]));
    chk({tag, ".32.data"},  64'(d32),  m_data[0]);
    chk({tag, ".32.wr"},    64'(we32), 64'(m_wr[0]));
    chk({tag, ".32.inst"},  i32,       m_inst[0]);
    chk({tag, ".64.valid"}, 64'(v64),  64'(m_valid[1]));
    chk({tag, ".64.rd"},    64'(rd64), 64'(m_rd[1]));
    chk({tag, ".64.data"},  d64,       m_data[1]);
    chk({tag, ".64.wr"},    64'(we64), 64'(m_wr[1]));
    chk({tag, ".64.inst"},  i64,       m_inst[1]);
    chk({tag, ".w.valid"},  64'(vw),   64'(m_valid[2]));
    chk({tag, ".w.rd"},     64'(rdw),  64'(m_rd[2]));
    chk({tag, ".w.data"},   64'(dw),   m_data[2]);
    chk({tag, ".w.wr"},     64'(wew),  64'(m_wr[2]));
    chk({tag, ".w.inst"},   64'(iw),   m_inst[2]);
  endtask

  // Inputs are driven at the falling edge; one rising edge, then sample 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [1:0] s,
                       input logic [2:0] code, input logic [63:0] a, input logic [63:0] d,
                       input logic w);
    mem_valid = v; mem_rd = rd; src = s; f3 = code; alu = a; rdata = d; wr = w;
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd3, 2'b00, 3'd0, 64'h55, 64'h0, 1'b1);
    pc4 = '0; csr = '0;
    model_reset();
    @(negedge clk);
    step("reset_hold");
    rst_n = 1'b1;

    drive(1'b1, 5'd5, 2'b00, 3'd0, 64'h1234, 64'h0, 1'b1);
    step("alu_wb");

    drive(1'b1, 5'd6, 2'b01, 3'd0, 64'h3, 64'h80FF7F01, 1'b1); step("lb_off3");
    drive(1'b1, 5'd7, 2'b01, 3'd4, 64'h1, 64'h80FF7F01, 1'b1); step("lbu_off1");
    drive(1'b1, 5'd8, 2'b01, 3'd1, 64'h2, 64'h80FF7F01, 1'b1); step("lh_off2");
    drive(1'b1, 5'd9, 2'b01, 3'd5, 64'h0, 64'h80FF7F01, 1'b1); step("lhu_off0");
    drive(1'b1, 5'd10, 2'b01, 3'd2, 64'h0, 64'h80FF7F01, 1'b1); step("lw");
    drive(1'b1, 5'd11, 2'b01, 3'd7, 64'h2, 64'h80FF7F01, 1'b1); step("ld_code7");

    pc4 = 64'h104;
    drive(1'b1, 5'd12, 2'b10, 3'd0, 64'h9, 64'h0, 1'b1); step("pc4");
    csr = 64'hABCD;
    drive(1'b1, 5'd13, 2'b11, 3'd0, 64'h9, 64'h0, 1'b1); step("csr");
    drive(1'b1, 5'd0, 2'b00, 3'd0, 64'h77, 64'h0, 1'b1); step("x0_write");
    drive(1'b1, 5'd14, 2'b00, 3'd0, 64'h42, 64'h0, 1'b0); step("no_wr");

    drive(1'b1, 5'd15, 2'b00, 3'd0, 64'hBEEF, 64'h0, 1'b1); step("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 2'b00, 3'd0, 64'(i + 1), 64'h0, 1'b1);
      step("stall");
    end
    stall = 1'b0;
    drive(1'b1, 5'd25, 2'b00, 3'd0, 64'hCAFE, 64'h0, 1'b1); step("stall_release");
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 5'd26, 2'b00, 3'd0, 64'hD00D, 64'h0, 1'b1); step("flush_stall");
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd27, 2'b00, 3'd0, 64'h1, 64'h0, 1'b1); step("after_flush");

    drive(1'b1, 5'd1, 2'b01, 3'd3, 64'h0, 64'h8000000000000000, 1'b1); step("ld64");
    drive(1'b1, 5'd2, 2'b01, 3'd6, 64'h4, 64'hFFFFFFFF80000000, 1'b1); step("lwu64_off4");
    drive(1'b1, 5'd3, 2'b01, 3'd2, 64'h0, 64'hFFFFFFFF80000000, 1'b1); step("lw64_off0");

    // Mid-stall asynchronous reset: outputs clear between clock edges.
    stall = 1'b1;
    async_reset("reset_mid_stall");
    stall = 1'b0;

    for (int i = 0; i < 300; i++) begin
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_rd    = 5'($urandom);
      src       = 2'($urandom);
      f3        = 3'($urandom);
      alu       = {$urandom, $urandom};
      rdata     = {$urandom, $urandom};
      pc4       = {$urandom, $urandom};
      csr       = {$urandom, $urandom};
      wr        = 1'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 6) == 0);
      step("random");
    end
    stall = 1'b0; flush = 1'b0;

    // Counter wrap on the 4-bit instance: 17 retirements read 15, 0, 1 at the end.
    async_reset("reset_wrap");
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 5'($urandom), 2'b00, 3'd0, {$urandom, $urandom}, 64'h0, 1'($urandom));
      step("wrap");
      if (i == 15) chk("wrap_15", 64'(iw), 64'd15);
      if (i == 16) chk("wrap_16", 64'(iw), 64'd0);
      if (i == 17) chk("wrap_17", 64'(iw), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
